// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
// The SEQ_CHUNK_ADDER_SUB_EN build adds a subtract-mode input to the top.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WIDTH_DEF = 16;
    localparam int CHUNK_DEF = 4;
    localparam int N_DEF     = num_chunks(WIDTH_DEF, CHUNK_DEF);

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// CHUNK-bit ripple-carry slice; also exposes the carry into its MSB
// so the caller can form signed overflow.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle valid/ready adder: one CHUNK-bit slice per clock, carry registered.
// Define SEQ_CHUNK_ADDER_SUB_EN to add the `sub` port (A + ~B + 1).
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = num_chunks(WIDTH, CHUNK);
    localparam int CW = cnt_width(N);

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] s_sum;
    logic             s_cout;
    logic             s_cmsb;
    logic             last;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                a_c = a_r[i*CHUNK +: CHUNK];
                b_c = b_r[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(.CHUNK(CHUNK)) u_slice (
        .a    (a_c),
        .b    (b_c),
        .cin  (carry),
        .s    (s_sum),
        .cout (s_cout),
        .cmsb (s_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b_eff;
                        carry <= cin_eff;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    carry <= s_cout;
                    for (int i = 0; i < N; i++) begin
                        if (cnt == CW'(i)) sum_r[i*CHUNK +: CHUNK] <= s_sum;
                    end
                    if (last) begin
                        cout_r <= s_cout;
                        ovf_r  <= s_cmsb ^ s_cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4).
// Directed corner cases, backpressure, mid-op reset and random operands.
module tb_seq_chunk_adder;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    logic             sub = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub       (sub),
`endif
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer add on 17 bits; subtract is a + ~b + 1.
    task automatic model(input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic s,
                         output logic [15:0] es, output logic ec,
                         output logic eo);
        logic [15:0] yy;
        logic [16:0] full;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
        es   = full[15:0];
        ec   = full[16];
        eo   = (x[15] == yy[15]) && (full[15] != x[15]);
    endtask

    // Called at a negedge with the block idle.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic s, input int hold,
                         input bit inject);
        logic [15:0] es;
        logic        ec;
        logic        eo;
        int          lat;
        model(x, y, c, s, es, ec, eo);
        check("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        sub = s;
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid = inject;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        sub = 1'($urandom);
`endif
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
            if (!out_valid) check("busy_in_ready", in_ready, 0);
        end
        check("latency", lat, N);
        check("sum", sum, es);
        check("cout", cout, ec);
        check("ovf", ovf, eo);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_sum", sum, es);
            check("hold_flags", {cout, ovf}, {ec, eo});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("consumed_valid", out_valid, 0);
        check("consumed_in_ready", in_ready, 1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h0001, 16'h0004, 1'b0, 1'b0, 0, 1'b0);
        check("dir_small", sum, 16'h0005);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        check("dir_ripple", {cout, sum}, 17'h10000);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1, 1'b0);
        check("dir_allones", {cout, sum}, 17'h1FFFF);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        check("dir_ovf", {ovf, cout, sum}, 18'h08000 | 18'h20000);
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 3, 1'b1);

        // Reset asserted in the second BUSY cycle.
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h1111;
        cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_flags", {cout, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_result", out_valid, 0);
        do_op(16'h0003, 16'h0002, 1'b0, 1'b0, 0, 1'b0);
        check("post_rst_sum", sum, 16'h0005);

`ifdef SEQ_CHUNK_ADDER_SUB_EN
        do_op(16'h0003, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
        check("sub_neg", {cout, sum}, 17'h0FFFE);
        do_op(16'h0005, 16'h0003, 1'b0, 1'b1, 0, 1'b0);
        check("sub_pos", {cout, sum}, 17'h10002);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        check("sub_ovf", ovf, 1);
`endif

        for (int r = 0; r < 24; r++) begin
            logic s;
            s = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
            s = 1'($urandom);
`endif
            do_op(16'($urandom), 16'($urandom), 1'($urandom), s,
                  int'($urandom_range(0, 2)), bit'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
